// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state encoding and default timing constants for the
//            stopwatch controller.
// Revision : 1.0
// ============================================================================
package stopwatch_pkg;

    localparam logic [4:0] c_ST_IDLE_OH  = 5'b00001;
    localparam logic [4:0] c_ST_RUN_OH   = 5'b00010;
    localparam logic [4:0] c_ST_PAUSE_OH = 5'b00100;
    localparam logic [4:0] c_ST_ADJ_OH   = 5'b01000;
    localparam logic [4:0] c_ST_CLEAR_OH = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE  = c_ST_IDLE_OH,
        ST_RUN   = c_ST_RUN_OH,
        ST_PAUSE = c_ST_PAUSE_OH,
        ST_ADJ   = c_ST_ADJ_OH,
        ST_CLEAR = c_ST_CLEAR_OH
    } state_t;

    localparam int unsigned c_TICK_DIV_DEFAULT   = 10_000_000;
    localparam int unsigned c_DEB_CYCLES_DEFAULT = 500_000;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : 2-flop synchronizer, level debouncer and rising-edge press pulse.
// Revision : 1.0
// ============================================================================
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic button,
    output logic press
);

    localparam int unsigned          c_CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;

    // The DEB_CYCLES-th consecutive differing sample flips the accepted level.
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_press <= w_accept && r_sync2;
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Stopwatch control FSM: debounced buttons, tick prescaler and
//            registered command pulses to the BCD datapath.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = c_TICK_DIV_DEFAULT,
    parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       one_button,
    input  logic       ten_button,
    input  logic       pause_button,
    input  logic       clear_button,
    output logic       count_en,
    output logic       add_one,
    output logic       add_ten,
    output logic       clr,
    output logic [4:0] fsm_state
);

    localparam int unsigned        c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    logic [3:0]         w_raw;
    logic [3:0]         w_press;
    logic               w_one, w_ten, w_pause, w_clear;

    state_t             r_state, w_state_nxt;
    state_t             r_origin, w_origin_nxt;
    logic               r_ten_sel, w_ten_sel_nxt;
    logic [c_PRE_W-1:0] r_presc, w_presc_nxt;
    logic               w_count_en_nxt;
    logic               r_count_en, r_add_one, r_add_ten, r_clr;

    assign w_raw = {clear_button, pause_button, ten_button, one_button};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .n_rst (n_rst),
            .button(w_raw[gi]),
            .press (w_press[gi])
        );
    end

    assign w_one   = w_press[0];
    assign w_ten   = w_press[1];
    assign w_pause = w_press[2];
    assign w_clear = w_press[3];

    // Priority clear > pause > ten > one falls out of the if/else ordering.
    always_comb begin
        w_state_nxt    = r_state;
        w_origin_nxt   = r_origin;
        w_ten_sel_nxt  = r_ten_sel;
        w_presc_nxt    = r_presc;
        w_count_en_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_presc_nxt = '0;
                if (w_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_pause) begin
                    w_state_nxt = ST_RUN;
                end else if (w_ten || w_one) begin
                    w_state_nxt   = ST_ADJ;
                    w_origin_nxt  = ST_IDLE;
                    w_ten_sel_nxt = w_ten;
                end
            end
            ST_RUN: begin
                if (w_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_pause) begin
                    w_state_nxt = ST_PAUSE;
                end else if (r_presc == c_PRE_LAST) begin
                    w_presc_nxt    = '0;
                    w_count_en_nxt = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (w_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_pause) begin
                    w_state_nxt = ST_RUN;
                end else if (w_ten || w_one) begin
                    w_state_nxt   = ST_ADJ;
                    w_origin_nxt  = ST_PAUSE;
                    w_ten_sel_nxt = w_ten;
                end
            end
            ST_ADJ:   w_state_nxt = r_origin;
            ST_CLEAR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt == ST_CLEAR) begin
            w_presc_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_origin   <= ST_IDLE;
            r_ten_sel  <= 1'b0;
            r_presc    <= '0;
            r_count_en <= 1'b0;
            r_add_one  <= 1'b0;
            r_add_ten  <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_origin   <= w_origin_nxt;
            r_ten_sel  <= w_ten_sel_nxt;
            r_presc    <= w_presc_nxt;
            r_count_en <= w_count_en_nxt;
            // ADJ never follows ADJ, so entering it is the only add trigger.
            r_add_ten  <= (w_state_nxt == ST_ADJ) && w_ten_sel_nxt;
            r_add_one  <= (w_state_nxt == ST_ADJ) && !w_ten_sel_nxt;
            r_clr      <= (w_state_nxt == ST_CLEAR);
        end
    end

    assign count_en  = r_count_en;
    assign add_one   = r_add_one;
    assign add_ten   = r_add_ten;
    assign clr       = r_clr;
    assign fsm_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed table-driven and sequence checks for stopwatch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int unsigned c_TICK = 10;
    localparam int unsigned c_DEB  = 4;
    localparam int          c_LAT  = c_DEB + 3;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_RUN   = 5'b00010;
    localparam logic [4:0] S_PAUSE = 5'b00100;
    localparam logic [4:0] S_ADJ   = 5'b01000;
    localparam logic [4:0] S_CLEAR = 5'b10000;

    // Button mask {clear, pause, ten, one}; pulse mask {count_en, add_one, add_ten, clr}.
    localparam logic [3:0] B_ONE   = 4'b0001;
    localparam logic [3:0] B_TEN   = 4'b0010;
    localparam logic [3:0] B_PAUSE = 4'b0100;
    localparam logic [3:0] B_CLEAR = 4'b1000;
    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_ONE   = 4'b0100;
    localparam logic [3:0] P_TEN   = 4'b0010;
    localparam logic [3:0] P_CLR   = 4'b0001;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       one_button = 1'b0;
    logic       ten_button = 1'b0;
    logic       pause_button = 1'b0;
    logic       clear_button = 1'b0;
    logic       count_en, add_one, add_ten, clr;
    logic [4:0] fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV  (c_TICK),
        .DEB_CYCLES(c_DEB)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .one_button  (one_button),
        .ten_button  (ten_button),
        .pause_button(pause_button),
        .clear_button(clear_button),
        .count_en    (count_en),
        .add_one     (add_one),
        .add_ten     (add_ten),
        .clr         (clr),
        .fsm_state   (fsm_state)
    );

    typedef struct {
        logic [4:0] start;
        logic [3:0] btn;
        logic [4:0] exp_state;
        logic [3:0] exp_pulse;
        logic [4:0] exp_after;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [3:0] pulses();
        return {count_en, add_one, add_ten, clr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        {clear_button, pause_button, ten_button, one_button} = m;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        set_btn(4'b0000);
        cyc(2);
        chk("reset_state", {27'd0, fsm_state}, {27'd0, S_IDLE});
        chk("reset_pulses", {28'd0, pulses()}, 32'd0);
        n_rst = 1'b1;
        cyc(1);
    endtask

    task automatic press(input logic [3:0] m);
        set_btn(m);
        cyc(c_LAT);
    endtask

    task automatic release_btn();
        set_btn(4'b0000);
        cyc(c_LAT);
    endtask

    int n;

    initial begin
        vecs[0]  = '{S_IDLE,  B_PAUSE,           S_RUN,   P_NONE, S_RUN};
        vecs[1]  = '{S_IDLE,  B_ONE,             S_ADJ,   P_ONE,  S_IDLE};
        vecs[2]  = '{S_IDLE,  B_TEN,             S_ADJ,   P_TEN,  S_IDLE};
        vecs[3]  = '{S_IDLE,  B_CLEAR,           S_CLEAR, P_CLR,  S_IDLE};
        vecs[4]  = '{S_IDLE,  B_TEN | B_ONE,     S_ADJ,   P_TEN,  S_IDLE};
        vecs[5]  = '{S_IDLE,  B_PAUSE | B_TEN,   S_RUN,   P_NONE, S_RUN};
        vecs[6]  = '{S_RUN,   B_ONE,             S_RUN,   P_NONE, S_RUN};
        vecs[7]  = '{S_RUN,   B_TEN,             S_RUN,   P_NONE, S_RUN};
        vecs[8]  = '{S_RUN,   B_PAUSE,           S_PAUSE, P_NONE, S_PAUSE};
        vecs[9]  = '{S_RUN,   B_CLEAR,           S_CLEAR, P_CLR,  S_IDLE};
        vecs[10] = '{S_PAUSE, B_TEN,             S_ADJ,   P_TEN,  S_PAUSE};
        vecs[11] = '{S_PAUSE, B_ONE,             S_ADJ,   P_ONE,  S_PAUSE};
        vecs[12] = '{S_PAUSE, B_PAUSE,           S_RUN,   P_NONE, S_RUN};
        vecs[13] = '{S_PAUSE, B_CLEAR | B_PAUSE, S_CLEAR, P_CLR,  S_IDLE};
        vecs[14] = '{S_IDLE,  B_CLEAR | B_PAUSE, S_CLEAR, P_CLR,  S_IDLE};

        for (int i = 0; i < 15; i++) begin
            do_reset();
            if (vecs[i].start != S_IDLE) begin
                press(B_PAUSE);
                release_btn();
            end
            if (vecs[i].start == S_PAUSE) begin
                press(B_PAUSE);
                release_btn();
            end
            press(vecs[i].btn);
            chk($sformatf("vec%0d_state", i), {27'd0, fsm_state}, {27'd0, vecs[i].exp_state});
            chk($sformatf("vec%0d_pulse", i), {28'd0, pulses()}, {28'd0, vecs[i].exp_pulse});
            cyc(1);
            chk($sformatf("vec%0d_after_state", i), {27'd0, fsm_state}, {27'd0, vecs[i].exp_after});
            chk($sformatf("vec%0d_after_pulse", i), {28'd0, pulses()}, 32'd0);
            set_btn(4'b0000);
        end

        // Long pause hold: one RUN entry, ticks every TICK_DIV cycles.
        do_reset();
        press(B_PAUSE);
        chk("hold_run_entry", {27'd0, fsm_state}, {27'd0, S_RUN});
        for (int idx = 1; idx <= 35; idx++) begin
            cyc(1);
            if (idx == 13) set_btn(4'b0000);
            chk($sformatf("hold_tick%0d", idx), {31'd0, count_en}, {31'd0, (idx % 10 == 0)});
            chk($sformatf("hold_state%0d", idx), {27'd0, fsm_state}, {27'd0, S_RUN});
        end

        // Pause after 23 RUN cycles, then resume from the held prescaler.
        do_reset();
        press(B_PAUSE);
        set_btn(4'b0000);
        n = 0;
        for (int idx = 1; idx <= 24; idx++) begin
            cyc(1);
            if (count_en) n++;
            if (idx == 17) set_btn(B_PAUSE);
        end
        chk("p23_state", {27'd0, fsm_state}, {27'd0, S_PAUSE});
        chk("p23_ticks", n, 2);
        release_btn();
        chk("p23_hold", {27'd0, fsm_state}, {27'd0, S_PAUSE});
        press(B_PAUSE);
        chk("p23_resume", {27'd0, fsm_state}, {27'd0, S_RUN});
        set_btn(4'b0000);
        for (int j = 1; j <= 9; j++) begin
            cyc(1);
            chk($sformatf("p23_tick%0d", j), {31'd0, count_en}, {31'd0, (j == 7)});
        end

        // Pause landing on the terminal count suppresses that tick.
        do_reset();
        press(B_PAUSE);
        set_btn(4'b0000);
        cyc(13);
        set_btn(B_PAUSE);
        cyc(c_LAT);
        chk("term_state", {27'd0, fsm_state}, {27'd0, S_PAUSE});
        chk("term_no_tick", {31'd0, count_en}, 32'd0);
        release_btn();
        press(B_PAUSE);
        chk("term_resume", {27'd0, fsm_state}, {27'd0, S_RUN});
        chk("term_tick_j0", {31'd0, count_en}, 32'd0);
        cyc(1);
        chk("term_tick_j1", {31'd0, count_en}, 32'd1);
        set_btn(4'b0000);

        // Bounce shorter than the debounce window.
        do_reset();
        set_btn(B_PAUSE); cyc(2);
        set_btn(4'b0000); cyc(2);
        set_btn(B_PAUSE); cyc(2);
        set_btn(4'b0000);
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            chk($sformatf("bounce_state%0d", k), {27'd0, fsm_state}, {27'd0, S_IDLE});
            chk($sformatf("bounce_pulse%0d", k), {28'd0, pulses()}, 32'd0);
        end

        // Asynchronous reset mid-RUN with the button still held.
        do_reset();
        press(B_PAUSE);
        cyc(3);
        #1;
        n_rst = 1'b0;
        #1;
        chk("arst_state", {27'd0, fsm_state}, {27'd0, S_IDLE});
        chk("arst_pulse", {28'd0, pulses()}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(c_LAT - 1);
        chk("arst_no_early", {27'd0, fsm_state}, {27'd0, S_IDLE});
        cyc(1);
        chk("arst_held_run", {27'd0, fsm_state}, {27'd0, S_RUN});
        set_btn(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clock cycles per count tick (>=2).
REQ-002 Parameter DEB_CYCLES, default 500_000, cycles a synchronized button level must stay stable to be accepted (>=1).
REQ-003 clk  input  1  single system clock, all logic rising-edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 one_button  input  1  raw asynchronous button, adds one unit when accepted.
REQ-006 ten_button  input  1  raw asynchronous button, adds ten units when accepted.
REQ-007 pause_button  input  1  raw asynchronous button, start/pause toggle.
REQ-008 clear_button  input  1  raw asynchronous button, clear to zero.
REQ-009 count_en  output  1  one-cycle pulse, BCD datapath increments by one.
REQ-010 add_one  output  1  one-cycle pulse, datapath adds 1.
REQ-011 add_ten  output  1  one-cycle pulse, datapath adds 10.
REQ-012 clr  output  1  one-cycle pulse, datapath clears to 00.
REQ-013 fsm_state  output  5  one-hot current state, for display/debug.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEB_CYCLES consecutive equal samples.
REQ-015 Each debouncer SHALL emit exactly one 1-cycle press pulse per accepted 0->1 transition, irrespective of hold length; release emits nothing.
REQ-016 Press latency SHALL be 2 + DEB_CYCLES cycles from raw rise to pulse; bounces shorter than DEB_CYCLES SHALL produce no pulse.
REQ-017 States (one-hot): IDLE=00001, RUN=00010, PAUSE=00100, ADJ=01000, CLEAR=10000.
REQ-018 Same-cycle press priority SHALL be clear > pause > ten > one; lower-priority pulses in that cycle are dropped.
REQ-019 IDLE: pause->RUN; one/ten->ADJ (origin=IDLE); clear->CLEAR.
REQ-020 RUN: pause->PAUSE; clear->CLEAR; one/ten ignored.
REQ-021 PAUSE: pause->RUN; one/ten->ADJ (origin=PAUSE); clear->CLEAR.
REQ-022 ADJ: exactly one cycle; add_ten if ten was the captured press else add_one; then return to origin; presses arriving in ADJ are dropped.
REQ-023 CLEAR: exactly one cycle, clr=1, then IDLE; prescaler zeroed.
REQ-024 Prescaler 0..TICK_DIV-1 SHALL increment only in RUN, hold in PAUSE/ADJ, be zero in IDLE/CLEAR.
REQ-025 count_en SHALL pulse in the RUN cycle where prescaler==TICK_DIV-1 (prescaler wraps to 0 same edge); first tick after IDLE->RUN occurs TICK_DIV cycles after entering RUN.
REQ-026 Pause pulse coincident with terminal count SHALL suppress that count_en; resume continues from the held prescaler value.
REQ-027 All pulse outputs registered; at most one of count_en/add_one/add_ten/clr high in any cycle.
REQ-028 99->00 wraparound belongs to the datapath; controller does not track count value.

Reset
REQ-029 n_rst low SHALL immediately force state IDLE (fsm_state=00001), origin=IDLE, prescaler 0, debouncers to stable-low, synchronizers 0, all pulse outputs 0.
REQ-030 Reset mid-press SHALL not produce a pulse on release of n_rst unless the button is then held DEB_CYCLES more cycles.

Structure
REQ-031 Shared package stopwatch_pkg SHALL hold the state enum (one-hot localparams) and default TICK_DIV/DEB_CYCLES constants.
REQ-032 One sub-module button_debounce (sync + debounce + edge pulse, parameter DEB_CYCLES), instantiated four times.
REQ-033 Counter widths SHALL be $clog2 of their parameters; no width truncation warnings.

Verification (bench: TICK_DIV=10, DEB_CYCLES=4)
REQ-034 Reset, hold pause 20 cycles -> one RUN entry, fsm_state=00010, count_en pulses every 10 cycles, first 10 cycles after RUN entry.
REQ-035 In RUN press pause after 23 RUN cycles -> PAUSE, 2 count_en seen; press pause again -> next count_en 7 cycles after RUN re-entry.
REQ-036 In PAUSE press ten then one -> ADJ each, add_ten then add_one single pulses, return to 00100; same presses in RUN -> no pulses.
REQ-037 Clear and pause rising the same cycle -> CLEAR (10000) one cycle, clr=1, then IDLE, no RUN.
REQ-038 Bounce pause 1-0-1-0 at 2-cycle intervals -> no pulse; assert n_rst mid-RUN -> fsm_state=00001 and outputs 0 same cycle.
